// File: rtl/apb_cmd_queue.sv
// Command FIFO and one-at-a-time issue sequencer in front of the APB master.
// A command is issued as a single-cycle cmd_o pulse, and the next one waits for the snooped APB completion.
module apb_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     req_valid_i,
  input  logic [1:0]               req_cmd_i,
  output logic                     req_ready_o,
  output logic [1:0]               cmd_o,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pready_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     rd_done_o,
  output logic                     wr_done_o,
  output logic [7:0]               drop_cnt_o,
  output logic                     timeout_o,
  input  logic                     clr_err_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [WW-1:0] sat_inc_wait(input logic [WW-1:0] v);
    return (v == WW'(TIMEOUT)) ? v : v + WW'(1);
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [1:0]      cur_cmd_q;
  logic            rd_done_q, wr_done_q;
  logic [7:0]      drop_q;
  logic            timeout_q;
  logic [WW-1:0]   wait_cnt_q;

  logic push, push_legal, push_illegal, pop, complete, timeout_set;

  assign req_ready_o  = (level_q != LW'(DEPTH));
  assign push         = req_valid_i & req_ready_o;
  assign push_legal   = push & req_cmd_i[0];
  assign push_illegal = push & ~req_cmd_i[0];
  assign pop          = (state_q == ISSUE);
  assign complete     = (state_q == WAIT) & psel_i & penable_i & pready_i;
  assign timeout_set  = (state_q == WAIT) & ~complete & (wait_cnt_q == WW'(TIMEOUT - 1));

  always_comb begin
    level_d = level_q;
    case ({push_legal, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // The WAIT exit looks at next-cycle occupancy so a push landing on the completion edge is issued without a gap.
  always_comb begin
    state_d = state_q;
    cmd_o   = 2'b00;
    case (state_q)
      IDLE:    if (level_q != '0) state_d = ISSUE;
      ISSUE: begin
        cmd_o   = mem[rd_ptr_q];
        state_d = WAIT;
      end
      WAIT:    if (complete) state_d = (level_d != '0) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage holds data only, so it carries no reset.
  always_ff @(posedge pclk) begin
    if (push_legal) mem[wr_ptr_q] <= req_cmd_i;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cur_cmd_q  <= 2'b00;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      drop_q     <= 8'd0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      rd_done_q <= complete & (cur_cmd_q == 2'b01);
      wr_done_q <= complete & (cur_cmd_q == 2'b11);
      if (push_legal) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PW'(1);
        cur_cmd_q <= mem[rd_ptr_q];
      end
      if (pop)
        wait_cnt_q <= '0;
      else if ((state_q == WAIT) && !complete)
        wait_cnt_q <= sat_inc_wait(wait_cnt_q);
      // Clear takes priority over a coincident set or count event.
      if (clr_err_i)
        timeout_q <= 1'b0;
      else if (timeout_set)
        timeout_q <= 1'b1;
      if (clr_err_i)
        drop_q <= 8'd0;
      else if (push_illegal)
        drop_q <= sat_inc8(drop_q);
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign level_o    = level_q;
  assign rd_done_o  = rd_done_q;
  assign wr_done_o  = wr_done_q;
  assign drop_cnt_o = drop_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Scoreboard bench for apb_cmd_queue: pushes record expected issues, a monitor checks cmd_o and done pulses.
// A small APB master/slave model answers each issued command with SETUP then ACCESS.
module tb_apb_cmd_queue;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       req_valid;
  logic [1:0] req_cmd;
  logic       req_ready;
  logic [1:0] cmd;
  logic       psel, penable, pready;
  logic       busy;
  logic [2:0] level;
  logic       rd_done, wr_done;
  logic [7:0] drop_cnt;
  logic       timeout;
  logic       clr_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp_cmd[$];
  logic [1:0] exp_done[$];
  int rd_cnt = 0;
  int wr_cnt = 0;

  int slave_wait = 1;
  bit stall = 1'b0;

  apb_cmd_queue #(.DEPTH(4), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid_i(req_valid), .req_cmd_i(req_cmd), .req_ready_o(req_ready),
    .cmd_o(cmd), .psel_i(psel), .penable_i(penable), .pready_i(pready),
    .busy_o(busy), .level_o(level), .rd_done_o(rd_done), .wr_done_o(wr_done),
    .drop_cnt_o(drop_cnt), .timeout_o(timeout), .clr_err_i(clr_err)
  );

  always #5 pclk = ~pclk;

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // APB model: phase 0 idle, 1 setup, 2 access.
  initial begin
    int bph;
    int wait_left;
    bit prev_issue;
    bph = 0; wait_left = 0; prev_issue = 1'b0;
    psel = 1'b0; penable = 1'b0; pready = 1'b0;
    forever begin
      @(posedge pclk or negedge preset_n);
      #1;
      if (!preset_n) begin
        bph = 0; prev_issue = 1'b0;
        psel = 1'b0; penable = 1'b0; pready = 1'b0;
      end else begin
        case (bph)
          0: if (prev_issue) begin
               psel = 1'b1; penable = 1'b0; pready = 1'b0;
               wait_left = slave_wait; bph = 1;
             end
          1: begin
               penable = 1'b1;
               pready  = (wait_left == 0) && !stall;
               bph = 2;
             end
          default: begin
               if (pready) begin
                 psel = 1'b0; penable = 1'b0; pready = 1'b0; bph = 0;
               end else begin
                 if (wait_left > 0) wait_left--;
                 pready = (wait_left == 0) && !stall;
               end
             end
        endcase
        prev_issue = (cmd != 2'b00);
      end
    end
  end

  // Monitor: every cmd_o pulse and done pulse is matched against the scoreboard.
  initial begin
    bit prev_nz;
    logic [1:0] e;
    prev_nz = 1'b0;
    forever begin
      @(negedge pclk);
      if (!preset_n) begin
        prev_nz = 1'b0;
      end else begin
        if (cmd != 2'b00) begin
          if (prev_nz) check("cmd_single_cycle", 1, 0);
          if (exp_cmd.size() == 0) begin
            check("cmd_unexpected", int'(cmd), 0);
          end else begin
            e = exp_cmd.pop_front();
            check("cmd_order", int'(cmd), int'(e));
            exp_done.push_back(e);
          end
        end
        prev_nz = (cmd != 2'b00);
        if (rd_done || wr_done) begin
          if (rd_done) rd_cnt++;
          if (wr_done) wr_cnt++;
          if (exp_done.size() == 0) begin
            check("done_unexpected", int'({wr_done, rd_done}), 0);
          end else begin
            e = exp_done.pop_front();
            check("done_type", int'({wr_done, rd_done}), (e == 2'b11) ? 2 : 1);
          end
        end
      end
    end
  end

  task automatic push(input logic [1:0] c);
    bit acc;
    int n;
    acc = 1'b0; n = 0;
    req_valid = 1'b1; req_cmd = c;
    while (!acc && n < 200) begin
      @(negedge pclk);
      acc = req_ready;
      @(posedge pclk);
      n++;
    end
    #1 req_valid = 1'b0;
    if (!acc) check("push_accept", 0, 1);
    else if (c[0]) exp_cmd.push_back(c);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy == 1'b0 && level == 3'd0 && exp_cmd.size() == 0 && exp_done.size() == 0) && n < 300) begin
      @(posedge pclk); #1;
      n++;
    end
    check("reach_idle", int'(n < 300), 1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge pclk); #1;
    clr_err = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_cmd"},     int'(cmd), 0);
    check({tag, "_ready"},   int'(req_ready), 1);
    check({tag, "_busy"},    int'(busy), 0);
    check({tag, "_level"},   int'(level), 0);
    check({tag, "_rd_done"}, int'(rd_done), 0);
    check({tag, "_wr_done"}, int'(wr_done), 0);
    check({tag, "_drop"},    int'(drop_cnt), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq[10];
    int rd0, mdl, cyc, idx, coinc;
    bit acc, pp;

    preset_n = 1'b0; req_valid = 1'b0; req_cmd = 2'b00; clr_err = 1'b0;
    repeat (3) @(posedge pclk);
    #1 check_reset_outputs("rst");
    @(negedge pclk) preset_n = 1'b1;
    @(posedge pclk); #1;

    // Single READ with idle-latency checks.
    slave_wait = 1; rd0 = rd_cnt;
    push(2'b01);
    check("lat_level", int'(level), 1);
    check("lat_busy0", int'(busy), 0);
    check("lat_cmd0", int'(cmd), 0);
    @(posedge pclk); #1;
    check("lat_cmd_issue", int'(cmd), 1);
    check("lat_busy1", int'(busy), 1);
    @(posedge pclk); #1;
    check("lat_cmd_drop", int'(cmd), 0);
    wait_idle();
    check("read_pulses", rd_cnt - rd0, 1);
    check("read_busy", int'(busy), 0);

    // Burst fill against a stalled slave.
    stall = 1'b1; slave_wait = 0;
    push(2'b01); push(2'b11); push(2'b01); push(2'b11); push(2'b11);
    check("full_level", int'(level), 4);
    check("full_ready", int'(req_ready), 0);
    req_valid = 1'b1; req_cmd = 2'b01;
    repeat (3) @(posedge pclk);
    #1 check("full_held_level", int'(level), 4);
    stall = 1'b0;
    push(2'b01);
    wait_idle();
    check("burst_timeout", int'(timeout), 0);

    // Illegal commands, clear, clear-wins and saturation.
    push(2'b00); push(2'b10); push(2'b01);
    wait_idle();
    check("drop_two", int'(drop_cnt), 2);
    pulse_clr();
    check("drop_clear", int'(drop_cnt), 0);
    clr_err = 1'b1;
    push(2'b00);
    clr_err = 1'b0;
    check("drop_clr_wins", int'(drop_cnt), 0);
    push(2'b10);
    check("drop_one", int'(drop_cnt), 1);
    for (int i = 0; i < 300; i++) push(2'b10);
    check("drop_sat", int'(drop_cnt), 255);
    pulse_clr();

    // Completion timeout on a WRITE.
    stall = 1'b1;
    push(2'b11);
    repeat (17) @(posedge pclk);
    #1 check("timeout_before", int'(timeout), 0);
    @(posedge pclk); #1;
    check("timeout_set", int'(timeout), 1);
    repeat (4) @(posedge pclk);
    #1 check("timeout_still_busy", int'(busy), 1);
    stall = 1'b0;
    wait_idle();
    check("timeout_sticky", int'(timeout), 1);
    pulse_clr();
    check("timeout_cleared", int'(timeout), 0);

    // Streamed alternating commands; level tracked against observed push/pop.
    for (int i = 0; i < 10; i++) seq[i] = (i % 2 == 0) ? 2'b01 : 2'b11;
    mdl = 0; cyc = 0; idx = 0; coinc = 0;
    while (idx < 10 && cyc < 400) begin
      req_valid = 1'b1; req_cmd = seq[idx];
      @(negedge pclk);
      acc = req_ready;
      pp  = (cmd != 2'b00);
      @(posedge pclk); #1;
      if (acc) begin
        exp_cmd.push_back(seq[idx]);
        idx++;
      end
      if (acc && pp) coinc++;
      mdl = mdl + int'(acc) - int'(pp);
      check("stream_level", int'(level), mdl);
      cyc++;
    end
    req_valid = 1'b0;
    check("stream_all_pushed", idx, 10);
    wait_idle();

    // Asynchronous reset while waiting with three queued commands.
    stall = 1'b1;
    push(2'b01); push(2'b11); push(2'b01); push(2'b11);
    check("prerst_level", int'(level), 3);
    check("prerst_busy", int'(busy), 1);
    #3 preset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_cmd.delete();
    exp_done.delete();
    stall = 1'b0;
    @(negedge pclk) preset_n = 1'b1;
    repeat (10) @(posedge pclk);
    #1 check("postrst_busy", int'(busy), 0);
    check("postrst_level", int'(level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
